// File: rtl/mips_main_control_pkg.sv
// rtl/mips_main_control_pkg.sv - opcode, ALUOP, PCSOURCE and state encodings for the main control FSM
package mips_main_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXEC   = 4'd6;
    localparam state_t S_ALUWB  = 4'd7;
    localparam state_t S_BRANCH = 4'd8;
    localparam state_t S_JUMP   = 4'd9;
    localparam state_t S_ADDIEX = 4'd10;
    localparam state_t S_ADDIWB = 4'd11;

endpackage

// File: rtl/mips_main_control.sv
// rtl/mips_main_control.sv - multi-cycle MIPS main control FSM; MIPS_CTRL_ADDI_EN adds ADDI decode
module mips_main_control
    import mips_main_control_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [5:0] OPCODE,
    input  logic       MEM_READY,
    output logic       PCWRITE,
    output logic       PCWRITECOND,
    output logic       IORD,
    output logic       MEMREAD,
    output logic       MEMWRITE,
    output logic       IRWRITE,
    output logic       REGDST,
    output logic       MEMTOREG,
    output logic       REGWRITE,
    output logic       ALUSRCA,
    output logic [1:0] ALUSRCB,
    output logic [1:0] ALUOP,
    output logic [1:0] PCSOURCE,
    output logic       ILLEGAL_OP,
    output logic [3:0] STATE
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign STATE = r_state;

    always_comb begin
        w_next_state = S_FETCH;
        PCWRITE      = 1'b0;
        PCWRITECOND  = 1'b0;
        IORD         = 1'b0;
        MEMREAD      = 1'b0;
        MEMWRITE     = 1'b0;
        IRWRITE      = 1'b0;
        REGDST       = 1'b0;
        MEMTOREG     = 1'b0;
        REGWRITE     = 1'b0;
        ALUSRCA      = 1'b0;
        ALUSRCB      = 2'b00;
        ALUOP        = ALUOP_ADD;
        PCSOURCE     = PCSRC_ALU;
        ILLEGAL_OP   = 1'b0;

        case (r_state)
            S_FETCH: begin
                MEMREAD      = 1'b1;
                ALUSRCB      = 2'b01;
                IRWRITE      = MEM_READY;
                PCWRITE      = MEM_READY;
                w_next_state = MEM_READY ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSRCB = 2'b11;
                case (OPCODE)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      w_next_state = S_ADDIEX;
`endif
                    default: begin
                        ILLEGAL_OP   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSRCA      = 1'b1;
                ALUSRCB      = 2'b10;
                w_next_state = (OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MEMREAD      = 1'b1;
                IORD         = 1'b1;
                w_next_state = MEM_READY ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                REGWRITE = 1'b1;
                MEMTOREG = 1'b1;
            end
            S_MEMWR: begin
                MEMWRITE     = MEM_READY;
                IORD         = 1'b1;
                w_next_state = MEM_READY ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSRCA      = 1'b1;
                ALUOP        = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                REGWRITE = 1'b1;
                REGDST   = 1'b1;
            end
            S_BRANCH: begin
                ALUSRCA     = 1'b1;
                ALUOP       = ALUOP_SUB;
                PCWRITECOND = 1'b1;
                PCSOURCE    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWRITE  = 1'b1;
                PCSOURCE = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSRCA      = 1'b1;
                ALUSRCB      = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                REGWRITE = 1'b1;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase

        // Reset holds FETCH, but no enable may reach the datapath until released
        if (!RESETN) begin
            PCWRITE     = 1'b0;
            IRWRITE     = 1'b0;
            MEMWRITE    = 1'b0;
            REGWRITE    = 1'b0;
            PCWRITECOND = 1'b0;
            ILLEGAL_OP  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_main_control.sv
// tb/tb_mips_main_control.sv - self-checking bench for mips_main_control
module tb_mips_main_control;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [5:0] OPCODE;
    logic       MEM_READY;
    logic       PCWRITE, PCWRITECOND, IORD, MEMREAD, MEMWRITE, IRWRITE;
    logic       REGDST, MEMTOREG, REGWRITE, ALUSRCA, ILLEGAL_OP;
    logic [1:0] ALUSRCB, ALUOP, PCSOURCE;
    logic [3:0] STATE;

    int checks = 0;
    int errors = 0;
    int path[$];

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
        logic       illegal;
    } ctrl_t;

    mips_main_control dut (
        .CLK(CLK), .RESETN(RESETN), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PCWRITE(PCWRITE), .PCWRITECOND(PCWRITECOND), .IORD(IORD),
        .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .IRWRITE(IRWRITE),
        .REGDST(REGDST), .MEMTOREG(MEMTOREG), .REGWRITE(REGWRITE),
        .ALUSRCA(ALUSRCA), .ALUSRCB(ALUSRCB), .ALUOP(ALUOP),
        .PCSOURCE(PCSOURCE), .ILLEGAL_OP(ILLEGAL_OP), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    function automatic bit addi_enabled();
`ifdef MIPS_CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Instruction-level state walk, one entry per state visited (stalls excluded)
    function automatic void build_path(input logic [5:0] op);
        path = {0, 1};
        case (op)
            6'b100011: path = {path, 2, 3, 4};
            6'b101011: path = {path, 2, 5};
            6'b000000: path = {path, 6, 7};
            6'b000100: path = {path, 8};
            6'b000010: path = {path, 9};
            6'b001000: if (addi_enabled()) path = {path, 10, 11};
            default: ;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b000010 ||
               (op == 6'b001000 && addi_enabled());
    endfunction

    function automatic ctrl_t expect_ctrl(input int st, input logic mr, input logic [5:0] op, input bit rst);
        ctrl_t c = '0;
        case (st)
            0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            1:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(op); end
            2, 10: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.memwrite = mr; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
            11: c.regwrite = 1;
            default: ;
        endcase
        if (rst) begin
            c.pcwrite = 0; c.irwrite = 0; c.memwrite = 0;
            c.regwrite = 0; c.pcwritecond = 0; c.illegal = 0;
        end
        return c;
    endfunction

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input int st, input logic mr, input logic [5:0] op, input bit rst, input string name);
        ctrl_t got, exp;
        got = {PCWRITE, PCWRITECOND, IORD, MEMREAD, MEMWRITE, IRWRITE, REGDST,
               MEMTOREG, REGWRITE, ALUSRCA, ALUSRCB, ALUOP, PCSOURCE, ILLEGAL_OP};
        exp = expect_ctrl(st, mr, op, rst);
        check_val({name, "_state"}, int'(STATE), st);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_ctrl: state %0d got %h expected %h at %0t", name, st, got, exp, $time);
        end
    endtask

    // Runs one instruction from FETCH; stalls are low MEM_READY cycles in FETCH and MEMRD/MEMWR
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input int exp_cycles, input string name);
        int idx = 0;
        int cyc = 0;
        int fs = fstall;
        int ms = mstall;
        int st;
        logic mr;
        bit waits;
        build_path(op);
        while (idx < path.size() && cyc < 40) begin
            st = path[idx];
            waits = (st == 0 || st == 3 || st == 5);
            if (st == 0) begin
                mr = (fs == 0);
                if (!mr) fs--;
            end else if (waits) begin
                mr = (ms == 0);
                if (!mr) ms--;
            end else begin
                mr = 1'($urandom_range(0, 1));
            end
            @(negedge CLK);
            MEM_READY = mr;
            OPCODE = (st == 0) ? 6'($urandom) : op;
            #1 check_cycle(st, mr, op, 1'b0, name);
            if (!waits || mr) idx++;
            cyc++;
        end
        check_val({name, "_cycles"}, cyc, exp_cycles);
    endtask

    initial begin
        RESETN = 1'b0;
        MEM_READY = 1'b1;
        OPCODE = 6'b000000;
        #1;
        check_val("por_state", int'(STATE), 0);
        check_val("por_irwrite", int'(IRWRITE), 0);
        check_val("por_memread", int'(MEMREAD), 1);
        repeat (2) begin
            @(negedge CLK);
            #1 check_cycle(0, MEM_READY, OPCODE, 1'b1, "por_hold");
        end
        #1 MEM_READY = 1'b0;
        RESETN = 1'b1;

        run_instr(6'b000000, 0, 0, 4, "rtype");
        run_instr(6'b100011, 0, 2, 7, "lw_stall");
        run_instr(6'b101011, 0, 0, 4, "sw");
        run_instr(6'b000100, 0, 0, 3, "beq");
        run_instr(6'b000010, 0, 0, 3, "j");
        run_instr(6'b111111, 0, 0, 2, "illegal");
        run_instr(6'b001000, 0, 0, addi_enabled() ? 4 : 2, "addi");
        run_instr(6'b101011, 1, 1, 6, "sw_stall");
        run_instr(6'b100011, 0, 0, 5, "lw");

        // Abandon an R-type in EXEC with an asynchronous reset
        @(negedge CLK); MEM_READY = 1'b1; OPCODE = 6'b010101;
        #1 check_cycle(0, 1'b1, OPCODE, 1'b0, "mid_fetch");
        @(negedge CLK); OPCODE = 6'b000000;
        #1 check_cycle(1, 1'b1, OPCODE, 1'b0, "mid_decode");
        @(negedge CLK);
        #1 check_cycle(6, 1'b1, OPCODE, 1'b0, "mid_exec");
        #1 RESETN = 1'b0;
        #1;
        check_val("async_state", int'(STATE), 0);
        check_val("async_regwrite", int'(REGWRITE), 0);
        repeat (2) begin
            @(negedge CLK);
            #1 check_cycle(0, MEM_READY, OPCODE, 1'b1, "rst_hold");
        end
        #1 MEM_READY = 1'b0;
        RESETN = 1'b1;
        run_instr(6'b000000, 0, 0, 4, "post_rst");
        run_instr(6'b000100, 2, 0, 5, "beq_fstall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_main_control.md
# mips_main_control

Multi-cycle MIPS main control FSM. Decodes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback, driving the datapath enables and the 2-bit ALU operation code consumed by the ALU control stage (which combines it with FUNCT to produce the 4-bit ALU control). Sits between the instruction register and the datapath/ALU control; one instruction in flight, memory-stall aware.

## Interface
Parameters:
- none. Opcode and state encodings are constants in the shared package.

Ports:
- CLK  in  1  single system clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- OPCODE  in  6  IR[31:26], sampled in DECODE and stable thereafter.
- MEM_READY  in  1  memory handshake; high = current read/write completes this cycle.
- PCWRITE, PCWRITECOND  out  1  PC write enable / conditional (beq) enable.
- IORD, MEMREAD, MEMWRITE, IRWRITE  out  1  memory address select, read, write, IR load.
- REGDST, MEMTOREG, REGWRITE  out  1  register-file controls.
- ALUSRCA  out  1; ALUSRCB  out  2  ALU operand selects.
- ALUOP  out  2  00 add, 01 subtract (branch compare), 10 use FUNCT.
- PCSOURCE  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target.
- ILLEGAL_OP  out  1  one-cycle pulse on unknown opcode.
- STATE  out  4  current state, for debug/verification.

## Operation
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000 (see Configuration).
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXEC(6), ALUWB(7), BRANCH(8), JUMP(9), ADDIEX(10), ADDIWB(11).
- Transitions: FETCH->DECODE when MEM_READY, else stay. DECODE: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX, other->FETCH with ILLEGAL_OP=1 that cycle. MEMADR->MEMRD (LW) or MEMWR (SW). MEMRD->MEMWB when MEM_READY. MEMWR->FETCH when MEM_READY. EXEC->ALUWB. ADDIEX->ADDIWB. ALUWB, MEMWB, ADDIWB, BRANCH, JUMP->FETCH.
- Moore outputs, unlisted signals 0:
  - FETCH: MEMREAD=1, ALUSRCB=01, ALUOP=00; IRWRITE=PCWRITE=MEM_READY.
  - DECODE: ALUSRCB=11, ALUOP=00.
  - MEMADR/ADDIEX: ALUSRCA=1, ALUSRCB=10, ALUOP=00.
  - MEMRD: MEMREAD=1, IORD=1. MEMWR: MEMWRITE=MEM_READY, IORD=1.
  - MEMWB: REGWRITE=1, MEMTOREG=1. ADDIWB: REGWRITE=1.
  - EXEC: ALUSRCA=1, ALUOP=10. ALUWB: REGWRITE=1, REGDST=1.
  - BRANCH: ALUSRCA=1, ALUOP=01, PCWRITECOND=1, PCSOURCE=01.
  - JUMP: PCWRITE=1, PCSOURCE=10.
- Write enables never assert outside their state; no two states assert REGWRITE and MEMWRITE together.

## Timing
- State register only sequential element; outputs combinational from state (plus MEM_READY qualification), no added latency.
- Cycles with MEM_READY tied high: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each low MEM_READY cycle in FETCH/MEMRD/MEMWR adds one cycle; outputs held, no enable pulses.
- Reset: RESETN low forces STATE=FETCH immediately (async). While low, PCWRITE, IRWRITE, MEMWRITE, REGWRITE, PCWRITECOND, ILLEGAL_OP forced 0; other outputs show FETCH values. First fetch cycle is the first rising edge after RESETN deasserts. Reset mid-instruction abandons it; no partial write.
- OPCODE changes outside DECODE ignored.

## Configuration
- MIPS_CTRL_ADDI_EN: defined -> ADDI decoded, ADDIEX/ADDIWB present. Undefined -> those states absent, opcode 001000 treated as illegal (ILLEGAL_OP pulse, return to FETCH); state codes 10/11 unreachable.

## Structure
- Shared package: opcode constants, ALUOP encodings (ADD/SUB/FUNCT), PCSOURCE encodings, state enum/typedef with fixed 4-bit values.
- Single module; next-state and output decode in one file. No sub-module needed.

## Test plan
- Reset mid-EXEC (RESETN low 2 cycles) -> STATE=0 asynchronously, REGWRITE=0 throughout, FETCH resumes one edge after release.
- R-type (OPCODE=000000), MEM_READY=1 -> states 0,1,6,7,0; ALUOP=10 in EXEC; REGWRITE=REGDST=1 only in ALUWB.
- LW with MEM_READY low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; REGWRITE/MEMTOREG only in MEMWB.
- SW, then BEQ, then J -> MEMWRITE single cycle in MEMWR; PCWRITECOND=1, ALUOP=01 in BRANCH; PCWRITE=1, PCSOURCE=10 in JUMP.
- OPCODE=111111 -> DECODE->FETCH, ILLEGAL_OP high exactly one cycle, no write enables.
- ADDI (001000) with and without MIPS_CTRL_ADDI_EN -> states 0,1,10,11,0 versus illegal path.
